dsc_bs2bin: RTL and testbench
=============================

// Module: dsc_bs2bin
// PURPOSE
//  Stochastic-to-binary decoder, the receive end of the DSC bitstream path.
//  Counts ones in a serial deterministic-stochastic bitstream over a fixed window of
//  2^WIDTH accepted bits, e.g. a stream from sng_dsc or an AND-ed product stream.
//  Returns the count as a binary word through a valid/ready output slot.
//  Backpressures the bitstream while the output slot is occupied.
// PARAMETERS
//  WIDTH  5  log2 of the window length in bits; window N = 2^WIDTH
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous, active-low reset
//  en         in   1        run enable; high = start/continue back-to-back windows
//  bs_in      in   1        stochastic bit
//  bs_valid   in   1        bs_in valid this cycle
//  bs_ready   out  1        decoder accepts bs_in this cycle
//  bin_out    out  WIDTH+2  decoded value; format set by CONFIGURATION
//  out_valid  out  1        bin_out holds an unconsumed result
//  out_ready  in   1        consumer takes bin_out this cycle
//  win_done   out  1        1-cycle pulse: a window just completed
//  busy       out  1        high while a window is in progress (state ACCUM)
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; bit_ctr=0, ones_ctr=0; bin_out=0.
//    out_valid=0, bs_ready=0, win_done=0, busy=0. Effective immediately, mid-window too.
//    A partial window is discarded.
//  - Accept = bs_valid & bs_ready. Only accepted bits advance bit_ctr or ones_ctr.
//  - bit_ctr: WIDTH bits. ones_ctr: WIDTH+1 bits, so an all-ones window gives N without wrap.
//  - FSM, 2 states:
//    IDLE : bs_ready=0. en=1 -> ACCUM next cycle; counters cleared.
//    ACCUM: bs_ready = !(bit_ctr==N-1 & out_valid & !out_ready).
//           The last bit of a window stalls until the slot is free or freed this cycle.
//           Each accept: bit_ctr++; ones_ctr += bs_in.
//           On accept with bit_ctr==N-1: the window completes. At the next edge:
//             result = ones_ctr + bs_in -> bin_out; out_valid=1; win_done=1 (1 cycle);
//             bit_ctr and ones_ctr return to 0.
//             en=1 -> stay ACCUM (next window starts the following cycle).
//             en=0 -> IDLE.
//  - Deasserting en mid-window does not abort; the current window finishes first.
//  - Latency: bin_out and out_valid update on the edge that accepts the Nth bit.
//  - Output slot:
//    out_valid & out_ready clears out_valid, unless a new result loads in the same
//    cycle; then bin_out takes the new value and out_valid stays 1.
//    bin_out holds steady while out_valid=1 and out_ready=0.
//  - bs_valid=0 cycles are bubbles; the window spans accepted bits, not clock cycles.
//  - bs_in is ignored when it is not accepted.
// CONFIGURATION
//  `DSC_BS2BIN_BIPOLAR_EN undefined (unipolar):
//    bin_out = {1'b0, ones}, unsigned, range 0..N.
//  `DSC_BS2BIN_BIPOLAR_EN defined (bipolar):
//    bin_out = 2*ones - N, two's complement, WIDTH+2 bits, range -N..+N.
//  - Port widths, FSM and handshake are identical in both modes.
// TESTING (WIDTH=5, N=32, bin_out 7 bits)
//  1. Reset: assert rst=0 mid-stream.
//     -> all outputs 0 at once; after release with en=0, design stays IDLE with bs_ready=0.
//  2. en=1, out_ready=1, 32 bits containing 12 ones, bs_valid always 1:
//     -> bin_out=7'h0C and out_valid=1 on the edge of the 32nd accept;
//     -> win_done pulses 1 cycle.
//  3. Boundaries: 32 ones -> bin_out=7'h20 (no wrap); 32 zeros -> bin_out=7'h00.
//     Random bs_valid bubbles -> same results.
//  4. Backpressure: out_ready=0 after result 12; feed a second window.
//     -> bs_ready=0 at bit 32 of window 2; bin_out stays 7'h0C;
//     -> raise out_ready: second result loads the same cycle and out_valid stays 1.
//  5. en dropped after 10 bits of a window:
//     -> window runs to 32 bits, result valid, FSM returns to IDLE with busy=0.
//  6. BIPOLAR_EN build:
//     12 ones -> 7'h78 (-8); 32 ones -> 7'h20 (+32); 0 ones -> 7'h60 (-32).

Source files
------------

// File: rtl/dsc_bs2bin_if.sv
// Bitstream input and decoded-result output handshakes for the DSC stochastic-to-binary decoder.
// The slave modport is the decoder's view; the master modport is the producer/consumer side.
interface dsc_bs2bin_if #(
  parameter int WIDTH = 5
);
  logic             bs_in;
  logic             bs_valid;
  logic             bs_ready;
  logic [WIDTH+1:0] bin_out;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  bs_in,
    input  bs_valid,
    output bs_ready,
    output bin_out,
    output out_valid,
    input  out_ready
  );

  modport master (
    output bs_in,
    output bs_valid,
    input  bs_ready,
    input  bin_out,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/dsc_bs2bin.sv
// Stochastic-to-binary decoder: counts ones over windows of 2^WIDTH accepted bits.
// Define DSC_BS2BIN_BIPOLAR_EN for bipolar output (2*ones - N); default is unipolar.
module dsc_bs2bin #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  dsc_bs2bin_if.slave      bus,
  output logic             win_done,
  output logic             busy
);

  localparam int N = 1 << WIDTH;
  localparam logic [WIDTH-1:0] LAST = {WIDTH{1'b1}};

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_bit_ctr;
  logic [WIDTH:0]   r_ones_ctr;
  logic [WIDTH+1:0] r_bin_out;
  logic             r_out_valid;
  logic             r_win_done;

  logic             w_bs_ready;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH:0]   w_ones_total;

  function automatic logic [WIDTH+1:0] f_format(input logic [WIDTH:0] ones);
`ifdef DSC_BS2BIN_BIPOLAR_EN
    logic signed [WIDTH+1:0] v;
    v = $signed({ones, 1'b0}) - $signed((WIDTH+2)'(N));
    return v;
`else
    return {1'b0, ones};
`endif
  endfunction

  // The final bit of a window waits until the output slot is free or being freed.
  assign w_bs_ready   = (r_state == ACCUM) &&
                        !((r_bit_ctr == LAST) && r_out_valid && !bus.out_ready);
  assign w_accept     = bus.bs_valid && w_bs_ready;
  assign w_last       = w_accept && (r_bit_ctr == LAST);
  assign w_ones_total = r_ones_ctr + (WIDTH+1)'(bus.bs_in);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (en) w_state_nxt = ACCUM;
      ACCUM:   if (w_last && !en) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Accumulation stage: counters advance only on accepted bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_ctr  <= '0;
      r_ones_ctr <= '0;
    end else if (r_state == IDLE || w_last) begin
      r_bit_ctr  <= '0;
      r_ones_ctr <= '0;
    end else if (w_accept) begin
      r_bit_ctr  <= r_bit_ctr + WIDTH'(1);
      r_ones_ctr <= w_ones_total;
    end
  end

  // Output slot stage: a new result overrides a same-cycle consume.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bin_out   <= '0;
      r_out_valid <= 1'b0;
      r_win_done  <= 1'b0;
    end else begin
      r_win_done <= w_last;
      if (w_last) begin
        r_bin_out   <= f_format(w_ones_total);
        r_out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.bs_ready  = w_bs_ready;
  assign bus.bin_out   = r_bin_out;
  assign bus.out_valid = r_out_valid;
  assign win_done      = r_win_done;
  assign busy          = (r_state == ACCUM);

endmodule

// File: tb/tb_dsc_bs2bin.sv
// Self-checking bench for dsc_bs2bin: directed scenarios with randomized bitstreams
// checked against a window-sum reference model (honours DSC_BS2BIN_BIPOLAR_EN).
module tb_dsc_bs2bin;

  localparam int WIDTH = 5;
  localparam int N     = 32;

`ifdef DSC_BS2BIN_BIPOLAR_EN
  localparam logic [6:0] EXP12 = 7'h78;
  localparam logic [6:0] EXP32 = 7'h20;
  localparam logic [6:0] EXP0  = 7'h60;
`else
  localparam logic [6:0] EXP12 = 7'h0C;
  localparam logic [6:0] EXP32 = 7'h20;
  localparam logic [6:0] EXP0  = 7'h00;
`endif

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic win_done;
  logic busy;

  dsc_bs2bin_if #(.WIDTH(WIDTH)) bus ();

  dsc_bs2bin #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .bus      (bus),
    .win_done (win_done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: accepted bits of the current window, plus the output slot.
  bit         acc_q[$];
  bit         m_busy;
  bit         m_valid;
  bit         m_done;
  logic [6:0] m_bin;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] fmt(input int s);
    int v;
`ifdef DSC_BS2BIN_BIPOLAR_EN
    v = 2 * s - N;
`else
    v = s;
`endif
    return v[6:0];
  endfunction

  function automatic logic [N-1:0] mk_bits(input int k);
    logic [N-1:0] r;
    int c;
    int p;
    r = '0;
    c = 0;
    while (c < k) begin
      p = $urandom_range(0, N - 1);
      if (!r[p]) begin
        r[p] = 1'b1;
        c++;
      end
    end
    return r;
  endfunction

  // One clock: drive at posedge+1, check bs_ready at negedge, check outputs at posedge+1.
  task automatic cycle(input logic v, input logic b, input logic o, input logic e);
    bit exp_ready;
    bit acc;
    bit was_busy;
    int s;
    en           = e;
    bus.bs_valid = v;
    bus.bs_in    = b;
    bus.out_ready = o;
    @(negedge clk);
    exp_ready = m_busy && !((acc_q.size() == N - 1) && m_valid && !o);
    chk("bs_ready", 32'(bus.bs_ready), 32'(exp_ready));
    acc = v && exp_ready;
    @(posedge clk);
    #1;
    was_busy = m_busy;
    m_done   = 1'b0;
    if (acc) acc_q.push_back(b);
    if (acc && acc_q.size() == N) begin
      s = 0;
      foreach (acc_q[i]) s += int'(acc_q[i]);
      acc_q.delete();
      m_bin   = fmt(s);
      m_valid = 1'b1;
      m_done  = 1'b1;
      m_busy  = e;
    end else begin
      if (m_valid && o) m_valid = 1'b0;
      if (!was_busy && e) m_busy = 1'b1;
    end
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("win_done", 32'(win_done), 32'(m_done));
    chk("busy", 32'(busy), 32'(m_busy));
    if (m_valid) chk("bin_out", 32'(bus.bin_out), 32'(m_bin));
  endtask

  // Feed one window; optional bubbles, output stall at the last bit, and en drop.
  task automatic feed_window(input logic [N-1:0] bits, input bit bubbles, input bit ordy,
                             input int stall_cycles, input int drop_en_at);
    int   idx;
    int   stall;
    bit   done;
    logic v;
    logic b;
    logic o;
    logic e;
    stall = 0;
    done  = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      idx = acc_q.size();
      v   = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      e   = (drop_en_at >= 0 && idx >= drop_en_at) ? 1'b0 : 1'b1;
      o   = ordy;
      if (idx == N - 1 && m_valid && !o) begin
        if (stall >= stall_cycles) o = 1'b1;
        stall++;
      end
      b = v ? bits[idx] : 1'($urandom_range(0, 1));
      cycle(v, b, o, e);
      done = m_done;
    end
    if (!done) chk("window_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] bits;
    rst = 1'b0; en = 1'b0;
    bus.bs_valid = 1'b0; bus.bs_in = 1'b0; bus.out_ready = 1'b0;
    acc_q.delete(); m_busy = 0; m_valid = 0; m_done = 0; m_bin = '0;

    // 1a. Reset state
    @(posedge clk); #1;
    chk("rst_bs_ready", 32'(bus.bs_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_bin_out", 32'(bus.bin_out), 0);
    chk("rst_win_done", 32'(win_done), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b1;

    // Stay idle with en=0, then start
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);

    // 2. Twelve ones, no bubbles
    feed_window(mk_bits(12), 1'b0, 1'b1, 0, -1);
    chk("res12", 32'(bus.bin_out), 32'(EXP12));

    // 3. Boundaries and bubbles
    feed_window({N{1'b1}}, 1'b0, 1'b1, 0, -1);
    chk("res32", 32'(bus.bin_out), 32'(EXP32));
    feed_window({N{1'b0}}, 1'b1, 1'b1, 0, -1);
    chk("res0", 32'(bus.bin_out), 32'(EXP0));
    feed_window(mk_bits(12), 1'b1, 1'b1, 0, -1);
    chk("res12_bubbles", 32'(bus.bin_out), 32'(EXP12));
    for (int k = 0; k < 3; k++) begin
      bits = N'($urandom());
      feed_window(bits, 1'b1, 1'b1, 0, -1);
      chk("res_random", 32'(bus.bin_out), 32'(fmt($countones(bits))));
    end

    // 4. Backpressure: result 12 held while window 2 stalls on its last bit
    feed_window(mk_bits(12), 1'b0, 1'b1, 0, -1);
    bits = mk_bits(20);
    feed_window(bits, 1'b1, 1'b0, 3, -1);
    chk("bp_valid", 32'(bus.out_valid), 1);
    chk("bp_res2", 32'(bus.bin_out), 32'(fmt(20)));
    cycle(1'b0, 1'b0, 1'b1, 1'b1);

    // 5. en dropped mid-window: window completes, then IDLE
    bits = mk_bits(7);
    feed_window(bits, 1'b1, 1'b1, 0, 10);
    chk("drop_res", 32'(bus.bin_out), 32'(fmt(7)));
    chk("drop_busy", 32'(busy), 0);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);

    // 1b. Async reset mid-window, partial window discarded
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    feed_window({N{1'b1}}, 1'b0, 1'b0, 0, -1);
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, 1'b0, 1'b1);
    #1 rst = 1'b0;
    #1;
    acc_q.delete(); m_busy = 0; m_valid = 0; m_done = 0; m_bin = '0;
    chk("arst_bs_ready", 32'(bus.bs_ready), 0);
    chk("arst_out_valid", 32'(bus.out_valid), 0);
    chk("arst_bin_out", 32'(bus.bin_out), 0);
    chk("arst_win_done", 32'(win_done), 0);
    chk("arst_busy", 32'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    feed_window({N{1'b1}}, 1'b1, 1'b1, 0, -1);
    chk("post_rst_res32", 32'(bus.bin_out), 32'(EXP32));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
